// File: rtl/mux_sel_serializer_if.sv
// Load/serial handshake bundle for mux_sel_serializer.
// slave = serializer side, master = upstream/downstream side.
interface mux_sel_serializer_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] data_hold;
    logic [2:0] sel;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_last;
    logic       ser_parity;
    logic       busy;

    modport slave (
        input  load_valid, load_data, ser_ready,
        output load_ready, data_hold, sel, ser_bit, ser_valid, ser_last, ser_parity, busy
    );

    modport master (
        output load_valid, load_data, ser_ready,
        input  load_ready, data_hold, sel, ser_bit, ser_valid, ser_last, ser_parity, busy
    );
endinterface

// File: rtl/mux_sel_serializer.sv
// Parallel-to-serial sequencer driving the 8:1 bit-select mux (data_hold + sel).
// Define SERIAL_PARITY_EN to append an even-parity beat after the 8 data beats.
module mux_sel_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_sel_serializer_if.slave  bus
);
    localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

`ifdef SERIAL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t     state;
    logic [7:0] data_hold;
    logic [2:0] sel;
    logic       ser_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_hold <= 8'h00;
            sel       <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        data_hold <= bus.load_data;
                        sel       <= START_IDX;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.ser_ready) begin
                        // sel parks on the end index; it never wraps inside a word
                        if (sel == END_IDX) begin
`ifdef SERIAL_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end else begin
                            sel <= MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
                        end
                    end
                end
`ifdef SERIAL_PARITY_EN
                PARITY: begin
                    if (bus.ser_ready) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ser_bit = 1'b0;
        case (state)
            SHIFT:   ser_bit = data_hold[sel];
`ifdef SERIAL_PARITY_EN
            PARITY:  ser_bit = ^data_hold;
`endif
            default: ser_bit = 1'b0;
        endcase
    end

    // Status outputs depend only on registered state/sel, never on the handshake inputs.
    assign bus.load_ready = (state == IDLE);
    assign bus.ser_valid  = (state != IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.data_hold  = data_hold;
    assign bus.sel        = sel;
    assign bus.ser_bit    = ser_bit;
`ifdef SERIAL_PARITY_EN
    assign bus.ser_last   = (state == PARITY);
    assign bus.ser_parity = (state == PARITY);
`else
    assign bus.ser_last   = (state == SHIFT) && (sel == END_IDX);
    assign bus.ser_parity = 1'b0;
`endif
endmodule

// File: tb/tb_mux_sel_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_mux_sel_serializer;
`ifdef SERIAL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [2:0] sel;
        logic       bitv;
        logic       last;
        logic       par;
        logic [7:0] word;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       ser_ready = 1'b1;
    int         checks = 0;
    int         errors = 0;
    beat_t      q[2][$];

    mux_sel_serializer_if ifc0();
    mux_sel_serializer_if ifc1();

    assign ifc0.load_valid = load_valid;
    assign ifc0.load_data  = load_data;
    assign ifc0.ser_ready  = ser_ready;
    assign ifc1.load_valid = load_valid;
    assign ifc1.load_data  = load_data;
    assign ifc1.ser_ready  = ser_ready;

    mux_sel_serializer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    mux_sel_serializer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_word(input int id, input bit msb, input logic [7:0] w);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = msb ? 7 - i : i;
            b.sel  = 3'(s);
            b.bitv = w[s];
            b.last = (i == 7) && !PAR;
            b.par  = 1'b0;
            b.word = w;
            q[id].push_back(b);
        end
        if (PAR) begin
            b.sel  = msb ? 3'd0 : 3'd7;
            b.bitv = ^w;
            b.last = 1'b1;
            b.par  = 1'b1;
            b.word = w;
            q[id].push_back(b);
        end
    endtask

    task automatic mon(input int id, input bit msb, input logic [7:0] dh, input logic [2:0] sl,
                       input logic sb, input logic sv, input logic sla, input logic spa,
                       input logic bsy, input logic lr);
        beat_t h;
        bit    act;
        act = (q[id].size() != 0);
        chk($sformatf("d%0d load_ready", id), 32'(lr), 32'(!act));
        chk($sformatf("d%0d busy", id), 32'(bsy), 32'(act));
        chk($sformatf("d%0d ser_valid", id), 32'(sv), 32'(act));
        if (act) begin
            h = q[id][0];
            chk($sformatf("d%0d sel", id), 32'(sl), 32'(h.sel));
            chk($sformatf("d%0d ser_bit", id), 32'(sb), 32'(h.bitv));
            chk($sformatf("d%0d ser_last", id), 32'(sla), 32'(h.last));
            chk($sformatf("d%0d ser_parity", id), 32'(spa), 32'(h.par));
            chk($sformatf("d%0d data_hold", id), 32'(dh), 32'(h.word));
            if (ser_ready) void'(q[id].pop_front());
        end else begin
            chk($sformatf("d%0d idle ser_last", id), 32'(sla), 32'd0);
            if (load_valid) push_word(id, msb, load_data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
        end else begin
            mon(0, 1'b0, ifc0.data_hold, ifc0.sel, ifc0.ser_bit, ifc0.ser_valid, ifc0.ser_last,
                ifc0.ser_parity, ifc0.busy, ifc0.load_ready);
            mon(1, 1'b1, ifc1.data_hold, ifc1.sel, ifc1.ser_bit, ifc1.ser_valid, ifc1.ser_last,
                ifc1.ser_parity, ifc1.busy, ifc1.load_ready);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, " d0 data_hold"}, 32'(ifc0.data_hold), 32'h00);
        chk({tag, " d0 sel"}, 32'(ifc0.sel), 32'd0);
        chk({tag, " d0 flags"},
            32'({ifc0.ser_valid, ifc0.ser_last, ifc0.ser_parity, ifc0.busy, ifc0.load_ready, ifc0.ser_bit}),
            32'b000010);
        chk({tag, " d1 sel"}, 32'(ifc1.sel), 32'd0);
        chk({tag, " d1 flags"},
            32'({ifc1.ser_valid, ifc1.ser_last, ifc1.ser_parity, ifc1.busy, ifc1.load_ready, ifc1.ser_bit}),
            32'b000010);
    endtask

    task automatic send(input logic [7:0] w);
        int n;
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = w;
        n = 0;
        while (!ifc0.load_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", 32'(n >= 200), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_sel(input logic [2:0] s);
        int n;
        n = 0;
        while (!(ifc0.busy && ifc0.sel == s) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait sel timeout", 32'(n >= 50), 32'd0);
    endtask

    initial begin
        #1;
        chk_reset("reset");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        send(8'hA6);
        wait_idle();

        send(8'h3C);
        send(8'h5A);
        wait_idle();

        // stall at sel=4, then a busy-time load of 8'hFF that must be ignored
        send(8'hA6);
        wait_sel(3'd4);
        ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ser_ready = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        wait_idle();

        send(8'h07);
        wait_idle();

        // alternating ready on a fresh word
        send(8'h96);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            ser_ready = i[0];
        end
        ser_ready = 1'b1;
        wait_idle();

        // reset mid-word at sel=3
        send(8'hC3);
        wait_sel(3'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("midword reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("post reset load_ready", 32'(ifc0.load_ready), 32'd1);

        send(8'h81);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
